// File: rtl/branch_pred_ctrl.sv
// Fetch-stage-2 branch predictor: 2-bit counter PHT plus an in-order queue of in-flight branches.
// Define BPRED_GSHARE_EN to XOR a global history register into the PHT index (default: bimodal).
module branch_pred_ctrl #(
  parameter int PHT_IDX_W = 6,
  parameter int Q_DEPTH   = 4,
  parameter int Q_PTR_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pcF2,
  input  logic               branchF2,
  input  logic               jumpF2,
  input  logic               stallF2,
  input  logic               resolve_valid,
  input  logic               resolve_taken,
  output logic               pred_takenF2,
  output logic               stall_reqF2,
  output logic               mispredict,
  output logic [Q_PTR_W:0]   q_count
);

  localparam int PHT_SIZE = 1 << PHT_IDX_W;
  localparam logic [Q_PTR_W:0] FULL_CNT = (Q_PTR_W + 1)'(Q_DEPTH);

  typedef struct packed {
    logic [PHT_IDX_W-1:0] idx;
    logic                 pred;
  } q_entry_t;

  logic [1:0]           pht_q   [PHT_SIZE];
  logic [1:0]           pht_d   [PHT_SIZE];
  q_entry_t             q_mem_q [Q_DEPTH];
  q_entry_t             q_mem_d [Q_DEPTH];
  logic [Q_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [Q_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [Q_PTR_W:0]     count_q, count_d;
  logic                 mispredict_q, mispredict_d;

  logic [PHT_IDX_W-1:0] idx;
  logic                 full;
  logic                 enq;
  logic                 deq;
  logic                 mis;
  q_entry_t             head;
  logic                 unused_pc_bits;

`ifdef BPRED_GSHARE_EN
  logic [PHT_IDX_W-1:0] ghr_q, ghr_d;
`endif

  assign unused_pc_bits = ^{pcF2[31:PHT_IDX_W+2], pcF2[1:0]};

  always_comb begin
`ifdef BPRED_GSHARE_EN
    idx = pcF2[PHT_IDX_W+1:2] ^ ghr_q;
`else
    idx = pcF2[PHT_IDX_W+1:2];
`endif
    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    full         = (count_q == FULL_CNT);
    pred_takenF2 = jumpF2 | (branchF2 & pht_q[idx][1]);
    stall_reqF2  = branchF2 & full;
    enq          = branchF2 & ~stallF2 & ~full;
    deq          = resolve_valid & (count_q != '0);
    head         = q_mem_q[rd_ptr_q];
    mis          = deq & (head.pred != resolve_taken);
  end

  always_comb begin
    pht_d        = pht_q;
    q_mem_d      = q_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    mispredict_d = mis;
`ifdef BPRED_GSHARE_EN
    ghr_d        = ghr_q;
`endif

    if (deq) begin
      if (resolve_taken) begin
        if (pht_q[head.idx] != 2'b11) pht_d[head.idx] = pht_q[head.idx] + 2'b01;
      end else begin
        if (pht_q[head.idx] != 2'b00) pht_d[head.idx] = pht_q[head.idx] - 2'b01;
      end
`ifdef BPRED_GSHARE_EN
      ghr_d = {ghr_q[PHT_IDX_W-2:0], resolve_taken};
`endif
    end

    // A mispredict squashes every younger entry, including one arriving this cycle.
    if (mis) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        q_mem_d[wr_ptr_q].idx  = idx;
        q_mem_d[wr_ptr_q].pred = pht_q[idx][1];
        wr_ptr_d = wr_ptr_q + (Q_PTR_W)'(1);
      end
      if (deq) rd_ptr_d = rd_ptr_q + (Q_PTR_W)'(1);
      count_d = count_q + {{Q_PTR_W{1'b0}}, enq} - {{Q_PTR_W{1'b0}}, deq};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHT_SIZE; i++) pht_q[i] <= 2'b01;
      for (int i = 0; i < Q_DEPTH; i++) q_mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      mispredict_q <= 1'b0;
`ifdef BPRED_GSHARE_EN
      ghr_q        <= '0;
`endif
    end else begin
      pht_q        <= pht_d;
      q_mem_q      <= q_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mispredict_q <= mispredict_d;
`ifdef BPRED_GSHARE_EN
      ghr_q        <= ghr_d;
`endif
    end
  end

  assign mispredict = mispredict_q;
  assign q_count    = count_q;

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Self-checking bench for branch_pred_ctrl: directed vector table, async-reset sequence,
// then random traffic against a queue-and-counter reference model.
module tb_branch_pred_ctrl;
  localparam int PHT_IDX_W = 6;
  localparam int Q_DEPTH   = 4;
  localparam int Q_PTR_W   = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [31:0]        pcF2 = '0;
  logic               branchF2 = 0, jumpF2 = 0, stallF2 = 0;
  logic               resolve_valid = 0, resolve_taken = 0;
  logic               pred_takenF2, stall_reqF2, mispredict;
  logic [Q_PTR_W:0]   q_count;

  always #5 clk = ~clk;

  branch_pred_ctrl #(.PHT_IDX_W(PHT_IDX_W), .Q_DEPTH(Q_DEPTH), .Q_PTR_W(Q_PTR_W)) dut (
    .clk(clk), .rst(rst), .pcF2(pcF2), .branchF2(branchF2), .jumpF2(jumpF2),
    .stallF2(stallF2), .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .pred_takenF2(pred_takenF2), .stall_reqF2(stall_reqF2), .mispredict(mispredict),
    .q_count(q_count)
  );

  typedef struct { int idx; bit pred; } entry_t;
  typedef struct {
    logic [31:0] pc;
    bit br, jp, st, rv, rt;
    bit ePred, eStall, eMis;
    int eCnt;
  } vec_t;

  int     pht [1 << PHT_IDX_W];
  entry_t mq[$];
  bit     expMis;
  int     ghr;
  int     checkCount = 0;
  int     passCount  = 0;
  vec_t   vecs [18];

  function automatic int idxOf(logic [31:0] pc);
    int i;
    i = int'((pc / 4) % (1 << PHT_IDX_W));
`ifdef BPRED_GSHARE_EN
    i = i ^ ghr;
`endif
    return i;
  endfunction

  function automatic void modelReset();
    foreach (pht[i]) pht[i] = 1;
    mq.delete();
    expMis = 0;
    ghr = 0;
  endfunction

  // Reference model: counters as integers, in-flight branches as a plain queue.
  function automatic void modelStep(logic [31:0] pc, bit br, bit st, bit rv, bit rt);
    entry_t nxt, h;
    bit enq, deq;
    nxt.idx = idxOf(pc);
    nxt.pred = (pht[nxt.idx] >= 2);
    enq = br && !st && (mq.size() < Q_DEPTH);
    deq = rv && (mq.size() != 0);
    expMis = 0;
    if (deq) begin
      h = mq.pop_front();
      if (rt) pht[h.idx] = (pht[h.idx] == 3) ? 3 : pht[h.idx] + 1;
      else    pht[h.idx] = (pht[h.idx] == 0) ? 0 : pht[h.idx] - 1;
      expMis = (h.pred != rt);
      ghr = ((ghr * 2) + int'(rt)) % (1 << PHT_IDX_W);
    end
    if (expMis) mq.delete();
    else if (enq) mq.push_back(nxt);
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic applyStimulus(logic [31:0] pc, bit br, bit jp, bit st, bit rv, bit rt);
    pcF2 = pc; branchF2 = br; jumpF2 = jp; stallF2 = st;
    resolve_valid = rv; resolve_taken = rt;
  endtask

  task automatic runCycle(string tag, logic [31:0] pc, bit br, bit jp, bit st, bit rv, bit rt,
                          output bit sPred, output bit sStall, output bit sMis, output int sCnt);
    bit mPred, mStall;
    @(negedge clk);
    applyStimulus(pc, br, jp, st, rv, rt);
    #1;
    mPred  = jp | (br & (pht[idxOf(pc)] >= 2));
    mStall = br & (mq.size() == Q_DEPTH);
    sPred = pred_takenF2; sStall = stall_reqF2;
    checkOutput({tag, ".pred"}, int'(sPred), int'(mPred));
    checkOutput({tag, ".stall"}, int'(sStall), int'(mStall));
    @(posedge clk);
    modelStep(pc, br, st, rv, rt);
    #1;
    sMis = mispredict; sCnt = int'(q_count);
    checkOutput({tag, ".mis"}, int'(sMis), int'(expMis));
    checkOutput({tag, ".cnt"}, sCnt, mq.size());
  endtask

  initial begin
    bit p, s, m;
    int c;

    vecs[0]  = '{32'h100, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{32'h100, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    vecs[2]  = '{32'h100, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[3]  = '{32'h100, 0, 0, 0, 1, 1, 0, 0, 1, 0};
    vecs[4]  = '{32'h100, 1, 0, 0, 0, 0, 1, 0, 0, 1};
    vecs[5]  = '{32'h100, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    vecs[6]  = '{32'h100, 1, 0, 1, 0, 0, 1, 0, 0, 0};
    vecs[7]  = '{32'h104, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[8]  = '{32'h108, 1, 0, 0, 0, 0, 0, 0, 0, 2};
    vecs[9]  = '{32'h10c, 1, 0, 0, 0, 0, 0, 0, 0, 3};
    vecs[10] = '{32'h110, 1, 0, 0, 0, 0, 0, 0, 0, 4};
    vecs[11] = '{32'h114, 1, 0, 0, 0, 0, 0, 1, 0, 4};
    vecs[12] = '{32'h114, 1, 0, 0, 1, 0, 0, 1, 0, 3};
    vecs[13] = '{32'h114, 1, 0, 1, 0, 0, 0, 0, 0, 3};
    vecs[14] = '{32'h118, 1, 0, 0, 1, 1, 0, 0, 1, 0};
    vecs[15] = '{32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[16] = '{32'h100, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    vecs[17] = '{32'h108, 1, 0, 1, 0, 0, 1, 0, 0, 0};

    modelReset();
    applyStimulus(32'h0, 0, 0, 0, 0, 0);
    #3;
    checkOutput("reset.cnt", int'(q_count), 0);
    checkOutput("reset.mis", int'(mispredict), 0);
    checkOutput("reset.pred", int'(pred_takenF2), 0);
    checkOutput("reset.stall", int'(stall_reqF2), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      runCycle($sformatf("vec%0d", i), vecs[i].pc, vecs[i].br, vecs[i].jp, vecs[i].st,
               vecs[i].rv, vecs[i].rt, p, s, m, c);
      checkOutput($sformatf("vec%0d.tblPred", i), int'(p), int'(vecs[i].ePred));
      checkOutput($sformatf("vec%0d.tblStall", i), int'(s), int'(vecs[i].eStall));
      checkOutput($sformatf("vec%0d.tblMis", i), int'(m), int'(vecs[i].eMis));
      checkOutput($sformatf("vec%0d.tblCnt", i), c, vecs[i].eCnt);
    end

    // Asynchronous reset in the middle of a cycle with two branches in flight.
    runCycle("pre0", 32'h108, 1, 0, 0, 0, 0, p, s, m, c);
    runCycle("pre1", 32'h10c, 1, 0, 0, 0, 0, p, s, m, c);
    checkOutput("pre.cnt2", c, 2);
    @(negedge clk);
    applyStimulus(32'h100, 1, 0, 1, 0, 0);
    #2 rst = 1'b1;
    modelReset();
    #1;
    checkOutput("midrst.cnt", int'(q_count), 0);
    checkOutput("midrst.mis", int'(mispredict), 0);
    for (int k = 0; k < (1 << PHT_IDX_W); k++) begin
      pcF2 = 32'(k * 4);
      #1;
      checkOutput($sformatf("midrst.pht%0d", k), int'(pred_takenF2), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    runCycle("post0", 32'h104, 1, 0, 0, 0, 0, p, s, m, c);
    runCycle("post1", 32'h104, 0, 0, 0, 1, 1, p, s, m, c);
    checkOutput("post1.tblMis", int'(m), 1);
    runCycle("post2", 32'h104, 1, 0, 1, 0, 0, p, s, m, c);
    checkOutput("post2.tblPred", int'(p), 1);

    for (int n = 0; n < 600; n++) begin
      bit br, jp;
      br = ($urandom_range(0, 99) < 55);
      jp = !br && ($urandom_range(0, 99) < 15);
      runCycle($sformatf("rnd%0d", n), 32'h100 + 32'(4 * $urandom_range(0, 7)), br, jp,
               ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 40),
               bit'($urandom_range(0, 1)), p, s, m, c);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
